ai_move_sel: RTL
================

AI_MOVE_SEL -- requirements
Module: ai_move_sel

Interface
REQ-001 Parameter THINK_CYCLES, default 8, sets the "thinking" delay in cycles; legal range 1..255.
REQ-002 Parameter LFSR_SEED, default 8'hA5, sets the LFSR reset value; SHALL be nonzero.
REQ-003 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  1  move request from control FSM (AI is active_trainer); only a rising edge is significant.
REQ-006 ack  input  1  control FSM has consumed the result.
REQ-007 p_hp  input  5  player HP, unsigned.
REQ-008 valid  output  1  result available; held until ack.
REQ-009 move  output  2  selected AI move index.
REQ-010 hit  output  1  accuracy roll result.
REQ-011 dmg  output  5  damage to apply: table damage if hit, else 0.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, THINK, PICK, ROLL, DONE; encoding comes from the shared package.
REQ-014 req rising edge SHALL be detected with a registered copy of req; the edge in IDLE moves to THINK and loads the counter with THINK_CYCLES-1.
REQ-015 THINK SHALL decrement the counter each cycle and go to PICK when it reads 0, giving exactly THINK_CYCLES cycles in THINK.
REQ-016 PICK SHALL sample p_hp and choose the move:
- Kill rule: if any table move has damage >= p_hp, choose the lowest such index.
- Otherwise choose lfsr[1:0].
- Then latch move and go to ROLL.
REQ-017 ROLL SHALL latch hit = (lfsr[7:4] < accuracy[move]) and dmg = hit ? damage[move] : 0, then go to DONE.
REQ-018 valid SHALL be high exactly while in DONE, first asserting THINK_CYCLES+2 edges after the edge that samples the req rise.
REQ-019 move, hit and dmg SHALL stay stable from ROLL exit until the next PICK/ROLL.
REQ-020 DONE with ack=1 SHALL go to IDLE, so valid drops on the next edge; ack outside DONE SHALL be ignored.
REQ-021 A req rising edge outside IDLE SHALL be ignored and not queued; ack and a req edge in the same DONE cycle: ack wins and the edge is lost.
REQ-022 p_hp=0 SHALL follow the kill rule (move 0).
REQ-023 Move table, with accuracy out of 16:
- move 0: damage 3, accuracy 15
- move 1: damage 5, accuracy 12
- move 2: damage 8, accuracy 8
- move 3: damage 12, accuracy 4
REQ-024 p_hp >= 13 SHALL always take the random path.
REQ-025 The LFSR SHALL be an 8-bit Galois x^8+x^6+x^5+x^4+1 that advances every cycle regardless of state and never reaches 0.

Reset
REQ-026 rst=1 SHALL immediately force the following, in any state including mid-THINK:
- state = IDLE, counter = 0, req history = 0, lfsr = LFSR_SEED.
- valid, busy, hit = 0; move = 0; dmg = 0.
REQ-027 A req held high across reset release SHALL NOT start a request; a fresh rising edge is required.

Structure
REQ-028 Shared package pbs_pkg SHALL hold the move damage/accuracy table, the state enum and the LFSR tap constant; the datapath uses the same table.
REQ-029 The LFSR SHALL be a separate sub-module pbs_lfsr8 (clock, reset, seed parameter, 8-bit state output).

Verification
REQ-030 THINK_CYCLES=4, p_hp=2, req rise -> valid rises 6 edges later; move=0; dmg=3 iff hit, else 0; busy high for those 6 cycles.
REQ-031 p_hp=7 -> move=2; p_hp=12 -> move=3; p_hp=20 -> move equals model lfsr[1:0] at PICK; hit and dmg match the reference-model LFSR.
REQ-032 Hold ack=0 for 10 cycles in DONE -> valid, move and dmg stable. Pulse ack -> valid=0 and busy=0 next cycle.
REQ-033 Pulse req again during THINK -> no second result; exactly one valid episode.
REQ-034 Assert rst mid-THINK -> all outputs 0 asynchronously; req held high through release -> stays IDLE until req falls and rises.
REQ-035 Run 1000 requests with random p_hp and random ack delay -> lfsr never 0, dmg <= 12, dmg=0 whenever hit=0, hit rate of move 3 near 4/16.

Source files
------------

// File: rtl/pbs_pkg.sv
// pbs_pkg -- shared definitions for the AI move selector.
//   state_t    : FSM state encoding (IDLE, THINK, PICK, ROLL, DONE)
//   MOVE_DMG   : damage per move index
//   MOVE_ACC   : accuracy per move index, out of 16
//   LFSR_TAPS  : Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
//   lfsr_next  : one LFSR step
package pbs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_THINK = 3'd1,
    ST_PICK  = 3'd2,
    ST_ROLL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int NUM_MOVES = 4;

  localparam logic [NUM_MOVES-1:0][4:0] MOVE_DMG = {5'd12, 5'd8, 5'd5, 5'd3};
  localparam logic [NUM_MOVES-1:0][3:0] MOVE_ACC = {4'd4, 4'd8, 4'd12, 4'd15};

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Right-shift Galois step; a nonzero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/ai_move_sel_if.sv
// ai_move_sel_if -- request/result bus between the battle control FSM and the
// AI move selector.
//   req, ack, p_hp            : driven by the control FSM (master)
//   valid, move, hit, dmg, busy : driven by the selector (slave)
interface ai_move_sel_if;
  logic       req;
  logic       ack;
  logic [4:0] p_hp;
  logic       valid;
  logic [1:0] move;
  logic       hit;
  logic [4:0] dmg;
  logic       busy;

  modport master (output req, ack, p_hp, input valid, move, hit, dmg, busy);
  modport slave  (input req, ack, p_hp, output valid, move, hit, dmg, busy);
endinterface

// File: rtl/pbs_lfsr8.sv
// pbs_lfsr8 -- free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1.
//   clk     : clock, advances every rising edge
//   rst     : asynchronous active-high reset, loads SEED
//   o_state : current LFSR state
// SEED must be nonzero or the register sticks at zero.
module pbs_lfsr8
  import pbs_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEED;
    else     r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/ai_move_sel.sv
// ai_move_sel -- picks the AI trainer's move after a fixed "thinking" delay.
//   CLOCK_50 : system clock
//   rst      : asynchronous active-high reset
//   bus      : slave side of ai_move_sel_if
//              req rise starts a selection, valid/move/hit/dmg hold the
//              result until ack, busy is high outside IDLE.
// Flow: IDLE -> THINK (THINK_CYCLES cycles) -> PICK (kill rule or random
// move) -> ROLL (accuracy roll) -> DONE (wait for ack).
module ai_move_sel
  import pbs_pkg::*;
#(
  parameter int         THINK_CYCLES = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  ai_move_sel_if.slave  bus
);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_req;
  logic       r_armed;
  logic [1:0] r_move;
  logic       r_hit;
  logic [4:0] r_dmg;

  logic [7:0] w_lfsr;
  logic [1:0] w_lfsr_unused;
  logic       w_req_rise;
  logic       w_kill;
  logic [1:0] w_kill_idx;
  logic       w_hit;

  pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (CLOCK_50),
    .rst     (rst),
    .o_state (w_lfsr)
  );

  assign w_lfsr_unused = w_lfsr[3:2];

  // r_armed stays low for the first edge after reset so that a req already
  // high at release is absorbed into r_req rather than seen as a rise.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_req   <= bus.req;
      r_armed <= 1'b1;
    end
  end

  assign w_req_rise = r_armed & bus.req & ~r_req;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: if (w_req_rise) begin
        w_state_nxt = ST_THINK;
        w_cnt_nxt   = 8'(THINK_CYCLES - 1);
      end
      ST_THINK: if (r_cnt == 8'd0) w_state_nxt = ST_PICK;
                else               w_cnt_nxt   = r_cnt - 8'd1;
      ST_PICK:  w_state_nxt = ST_ROLL;
      ST_ROLL:  w_state_nxt = ST_DONE;
      ST_DONE:  if (bus.ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Kill rule: scan high-to-low so the lowest qualifying index wins.
  always_comb begin
    w_kill     = 1'b0;
    w_kill_idx = 2'd0;
    for (int i = NUM_MOVES - 1; i >= 0; i--) begin
      if (MOVE_DMG[i] >= bus.p_hp) begin
        w_kill     = 1'b1;
        w_kill_idx = 2'(i);
      end
    end
  end

  assign w_hit = (w_lfsr[7:4] < MOVE_ACC[r_move]);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_move <= 2'd0;
      r_hit  <= 1'b0;
      r_dmg  <= 5'd0;
    end else begin
      if (r_state == ST_PICK) r_move <= w_kill ? w_kill_idx : w_lfsr[1:0];
      if (r_state == ST_ROLL) begin
        r_hit <= w_hit;
        r_dmg <= w_hit ? MOVE_DMG[r_move] : 5'd0;
      end
    end
  end

  assign bus.valid = (r_state == ST_DONE);
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.move  = r_move;
  assign bus.hit   = r_hit;
  assign bus.dmg   = r_dmg;

endmodule
